vga_pixel_apb_master: RTL
=========================

VGA_PIXEL_APB_MASTER -- requirements
Module: vga_pixel_apb_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h2100_0000, framebuffer base byte address.
REQ-002 SHALL have parameter H_RES, default 640, pixels per line.
REQ-003 SHALL have parameter V_RES, default 480, lines per frame.
REQ-004 SHALL have ports:
  - clock  input  1  sole clock; all logic on posedge.
  - reset  input  1  synchronous, active-high.
  - s_valid  input  1  pixel offered.
  - s_ready  output  1  pixel accepted when s_valid & s_ready.
  - s_data  input  24  pixel {R[23:16], G[15:8], B[7:0]}.
  - s_sof  input  1  this pixel is frame start (index 0).
  - out_paddr  output  32  APB address.
  - out_psel  output  1  APB select.
  - out_penable  output  1  APB enable.
  - out_pwrite  output  1  APB write.
  - out_pwdata  output  32  APB write data.
  - out_pstrb  output  4  APB strobes.
  - out_pprot  output  3  APB protection.
  - out_pready  input  1  slave ready.
  - out_prdata  input  32  unused.
  - out_pslverr  input  1  slave error.
  - frame_done  output  1  one-cycle pulse, last pixel of frame written.
  - err  output  1  sticky, slave error seen.
  - busy  output  1  buffer non-empty or APB transfer in progress.

Function
REQ-005 SHALL buffer accepted pixels, each with its s_sof bit, in FIFO order; s_ready = buffer not full, regardless of a same-cycle pop.
REQ-006 SHALL run APB FSM IDLE -> SETUP -> ACCESS: IDLE->SETUP when buffer non-empty; SETUP->ACCESS unconditionally; in ACCESS hold until out_pready=1, then pop head, go SETUP if buffer still non-empty after pop, else IDLE.
REQ-007 SHALL drive out_psel=1 in SETUP and ACCESS, out_penable=1 only in ACCESS, both 0 in IDLE.
REQ-008 SHALL hold out_paddr, out_pwdata, out_pstrb constant from SETUP through the completing ACCESS cycle.
REQ-009 SHALL drive out_pwrite=1, out_pstrb=4'hF, out_pprot=3'b000, out_pwdata={8'h00, pixel} during transfers.
REQ-010 SHALL keep 19-bit linear index idx; the transfer index is 0 if head sof=1, else idx.
REQ-011 SHALL set out_paddr = BASE_ADDR + transfer_index*4, computed by increment, no multiplier.
REQ-012 SHALL on each completed transfer set idx = transfer_index+1, or 0 if transfer_index = H_RES*V_RES-1.
REQ-013 SHALL pulse frame_done for one cycle, in the cycle after the completed transfer with transfer_index = H_RES*V_RES-1.
REQ-014 SHALL set err when out_pslverr=1 in a completing ACCESS cycle; the pixel is dropped (no retry) and idx still advances.
REQ-015 SHALL give latency: pixel accepted in cycle N into empty buffer with FSM IDLE -> SETUP in N+1, ACCESS in N+2.
REQ-016 SHALL sustain one pixel per two cycles with a zero-wait slave.
REQ-017 SHALL ignore out_prdata.

Reset
REQ-018 SHALL on reset: FSM IDLE; buffer empty; idx=0.
REQ-019 SHALL on reset drive out_psel=0, out_penable=0, out_pwrite=0, out_paddr=0, out_pwdata=0, out_pstrb=0, out_pprot=0, frame_done=0, err=0, busy=0, s_ready=0 during reset cycle and 1 thereafter.
REQ-020 SHALL, on reset during ACCESS, abandon the transfer and discard buffered pixels.

Configuration
REQ-021 SHALL with VGA_PIXEL_FIFO_EN defined use a 4-entry circular FIFO with 3-bit count (full at 4).
REQ-022 SHALL without VGA_PIXEL_FIFO_EN use a single-entry holding register; s_ready=1 only when it is empty; same FSM, addressing and timing otherwise.

Verification
REQ-023 SHALL cover: reset, then one pixel 24'h123456 with s_sof=1 -> SETUP next cycle, paddr=32'h2100_0000, pwdata=32'h0012_3456, pstrb=4'hF.
REQ-024 SHALL cover: three pixels, no sof, slave pready=1 -> paddrs 0x2100_0004, 0x2100_0008, 0x2100_000C; psel high 6 consecutive cycles, penable alternating.
REQ-025 SHALL cover: slave holds pready=0 for 5 cycles -> addr/data stable; with FIFO_EN, s_ready drops after 4 further pixels accepted; without FIFO_EN, after 1.
REQ-026 SHALL cover: 307200 pixels from sof -> last paddr=0x2112_BFFC, frame_done pulses exactly once, next pixel without sof writes 0x2100_0000.
REQ-027 SHALL cover: pslverr=1 on second transfer -> err=1 until reset; third write at 0x2100_0008.
REQ-028 SHALL cover: sof mid-frame at idx=100 -> that pixel at 0x2100_0000, following pixel at 0x2100_0004; and reset asserted during ACCESS -> psel=0 next cycle, busy=0.

Source files
------------

// File: rtl/vga_pixel_apb_master.sv
// vga_pixel_apb_master: buffers RGB pixels and writes them to a linear framebuffer over APB; define VGA_PIXEL_FIFO_EN for a 4-entry buffer instead of a single holding register
module vga_pixel_apb_master #(
  parameter logic [31:0] BASE_ADDR = 32'h2100_0000,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  output logic [2:0]  out_pprot,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr,
  output logic        frame_done,
  output logic        err,
  output logic        busy
);
  localparam logic [18:0] LAST_IDX = 19'(H_RES * V_RES - 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic push, pop, empty, full, more, head_sof, last;
  logic [23:0] head_data;
  logic [18:0] idx, tidx;
  logic [31:0] addr;
  logic unused_prdata;
  assign unused_prdata = ^out_prdata;
  assign push = s_valid & s_ready;
  assign pop = (state == ACCESS) & out_pready;
  assign s_ready = ~reset & ~full;
  assign busy = ~empty;
`ifdef VGA_PIXEL_FIFO_EN
  logic [24:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count, count_next;
  assign count_next = count + {2'b0, push} - {2'b0, pop};
  assign empty = count == 3'd0;
  assign full = count == 3'd4;
  assign more = count_next != 3'd0;
  assign {head_sof, head_data} = mem[rd_ptr];
  // pixel storage, each entry tagged with its start-of-frame bit
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= {s_sof, s_data};
  // circular pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + {1'b0, push};
      rd_ptr <= rd_ptr + {1'b0, pop};
      count <= count_next;
    end
  end
`else
  logic [24:0] hold;
  logic valid;
  assign empty = ~valid;
  assign full = valid;
  assign more = push | (valid & ~pop);
  assign {head_sof, head_data} = hold;
  // single pixel holding register
  always_ff @(posedge clock)
    if (push) hold <= {s_sof, s_data};
  // occupancy of the holding register
  always_ff @(posedge clock)
    valid <= reset ? 1'b0 : more;
`endif
  // a start-of-frame pixel restarts addressing at the framebuffer base
  assign tidx = head_sof ? '0 : idx;
  assign last = tidx == LAST_IDX;
  assign out_paddr = out_psel ? (head_sof ? BASE_ADDR : addr) : '0;
  assign out_pwdata = out_psel ? {8'h00, head_data} : '0;
  assign out_pstrb = out_psel ? 4'hF : 4'h0;
  assign out_pwrite = out_psel;
  assign out_pprot = 3'b000;
  // APB phase sequencing, running pixel index/address and status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      out_psel <= 1'b0;
      out_penable <= 1'b0;
      idx <= '0;
      addr <= BASE_ADDR;
      frame_done <= 1'b0;
      err <= 1'b0;
    end else begin
      frame_done <= pop & last;
      unique case (state)
        IDLE: if (more) begin
          state <= SETUP;
          out_psel <= 1'b1;
        end
        SETUP: begin
          state <= ACCESS;
          out_penable <= 1'b1;
        end
        ACCESS: if (out_pready) begin
          state <= more ? SETUP : IDLE;
          out_psel <= more;
          out_penable <= 1'b0;
          idx <= last ? '0 : tidx + 19'd1;
          addr <= last ? BASE_ADDR : (head_sof ? BASE_ADDR : addr) + 32'd4;
          err <= err | out_pslverr;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
